cm0_pmu_cdc_req_tx: RTL

CM0_PMU_CDC_REQ_TX -- requirements
Module: cm0_pmu_cdc_req_tx

---
 rtl/cm0_pmu_cdc_pkg.sv | 21 ++
 rtl/cm0_pmu_cdc_sync_bit.sv | 34 +++
 rtl/cm0_pmu_cdc_req_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cm0_pmu_cdc_pkg.sv
// ---------------------------------------------------------------------------
// cm0_pmu_cdc_pkg
// Shared definitions for the PMU request-side clock-domain crossing.
// Holds the handshake FSM state type and the default parameter values
// used by cm0_pmu_cdc_req_tx and cm0_pmu_cdc_sync_bit.
// No ports (package).
// ---------------------------------------------------------------------------
package cm0_pmu_cdc_pkg;

  // Four-phase handshake progress seen from the sending side
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } cdc_state_e;

  localparam int CDC_DEFAULT_DATA_WIDTH  = 8;
  localparam int CDC_DEFAULT_SYNC_STAGES = 2;
  localparam int CDC_DEFAULT_TIMEOUT     = 1024;

endpackage

// File: rtl/cm0_pmu_cdc_sync_bit.sv
// ---------------------------------------------------------------------------
// cm0_pmu_cdc_sync_bit
// Single-bit level synchroniser: a STAGES-deep flop chain clocked by SYNCCLK.
// Kept as its own module so it can be swapped for a library synchroniser cell.
// Ports:
//   SYNCCLK  in   destination clock
//   SYNCRST  in   synchronous active-high reset, clears every stage to 0
//   d        in   asynchronous input level
//   q        out  synchronised level (last stage of the chain)
// ---------------------------------------------------------------------------
module cm0_pmu_cdc_sync_bit
  import cm0_pmu_cdc_pkg::*;
#(
  parameter int STAGES = CDC_DEFAULT_SYNC_STAGES
) (
  input  logic SYNCCLK,
  input  logic SYNCRST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge SYNCCLK) begin
    if (SYNCRST) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cm0_pmu_cdc_req_tx.sv
// ---------------------------------------------------------------------------
// cm0_pmu_cdc_req_tx
// Sending side of a four-phase request/acknowledge crossing. A local
// valid/ready transfer is latched into CDCDATA and announced by raising
// CDCREQ; the remote acknowledge is synchronised, CDCREQ is dropped once it
// is seen high, and DONE pulses once it is seen low again. A stall counter
// flags STALLED (sticky until DONE or reset) when a phase lasts too long,
// without ever aborting the handshake.
// Ports:
//   SYNCCLK   in   sole clock
//   SYNCRST   in   synchronous active-high reset
//   REQVALID  in   local request to send REQDATA
//   REQDATA   in   payload, captured on acceptance
//   REQREADY  out  block can accept (combinational from registered state)
//   CDCREQ    out  registered request level to remote domain
//   CDCDATA   out  registered payload to remote domain
//   CDCACK    in   asynchronous acknowledge level from remote domain
//   DONE      out  one-cycle pulse on handshake completion
//   STALLED   out  sticky timeout flag
// ---------------------------------------------------------------------------
module cm0_pmu_cdc_req_tx
  import cm0_pmu_cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = CDC_DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES    = CDC_DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = CDC_DEFAULT_TIMEOUT
) (
  input  logic                  SYNCCLK,
  input  logic                  SYNCRST,
  input  logic                  REQVALID,
  input  logic [DATA_WIDTH-1:0] REQDATA,
  output logic                  REQREADY,
  output logic                  CDCREQ,
  output logic [DATA_WIDTH-1:0] CDCDATA,
  input  logic                  CDCACK,
  output logic                  DONE,
  output logic                  STALLED
);

  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES);

  cdc_state_e state, state_nxt;

  logic                  ack_s;
  logic                  accept;
  logic                  finish;
  logic                  moving;
  logic                  cdc_req_q;
  logic [DATA_WIDTH-1:0] cdc_data_q;
  logic                  done_q;
  logic                  stalled_q;
  logic [CNT_W-1:0]      stall_cnt;
  logic [SETTLE_W-1:0]   settle_cnt;

  cm0_pmu_cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .SYNCCLK (SYNCCLK),
    .SYNCRST (SYNCRST),
    .d       (CDCACK),
    .q       (ack_s)
  );

  // Reset flushes the synchroniser to 0, which would hide a remote ack that
  // is still high. Readiness is therefore held off until the chain has been
  // refilled with real samples, so the remote side always finishes its
  // four-phase cycle before a new request can start.
  always_ff @(posedge SYNCCLK) begin
    if (SYNCRST) begin
      settle_cnt <= '0;
    end else if (settle_cnt != SETTLE_MAX) begin
      settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  always_ff @(posedge SYNCCLK) begin
    if (SYNCRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    REQREADY  = (state == ST_IDLE) && !ack_s && (settle_cnt == SETTLE_MAX);
    accept    = REQVALID && REQREADY;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (ack_s) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    moving = (state_nxt != state);
  end

  // Registered outputs. The stall counter restarts on every transition and
  // STALLED is set on the edge where the count arrives at the timeout.
  always_ff @(posedge SYNCCLK) begin
    if (SYNCRST) begin
      cdc_req_q  <= 1'b0;
      cdc_data_q <= '0;
      done_q     <= 1'b0;
      stalled_q  <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      cdc_req_q <= (state_nxt == ST_REQ);
      done_q    <= finish;
      if (accept) begin
        cdc_data_q <= REQDATA;
      end
      if (moving) begin
        stall_cnt <= '0;
      end else if (state != ST_IDLE && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (finish) begin
        stalled_q <= 1'b0;
      end else if (!moving && state != ST_IDLE && stall_cnt == CNT_LAST) begin
        stalled_q <= 1'b1;
      end
    end
  end

  assign CDCREQ  = cdc_req_q;
  assign CDCDATA = cdc_data_q;
  assign DONE    = done_q;
  assign STALLED = stalled_q;

`ifdef ARM_ASSERT_ON
  cdcack_xcheck: assert property (@(posedge SYNCCLK) disable iff (SYNCRST) !$isunknown(CDCACK));
`endif

endmodule
